pdm_stereo_capture: RTL and testbench

- Two-channel PDM-to-PCM front end. Both microphones share one data line: channel 0 (left) is sampled at the end of the pdm_clk high phase, channel 1 (right) at the end of the low phase.
- Generates pdm_clk and runs one parametrised N-stage CIC decimator per channel.
- Applies a runtime gain shift with saturation and delivers stereo frames on a valid/ready stream with overrun detection.
- Sits between the microphone pins and the audio FIFO/DMA path.

---
 rtl/pdm_stereo_capture.sv | 205 ++++++++++++++++++++
 tb/tb_pdm_stereo_capture.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_stereo_capture.sv
// pdm_stereo_capture: two-microphone PDM front end sharing one data line.
// Generates pdm_clk, runs an N-stage CIC decimator per channel, then applies
// gain and saturation, and presents stereo frames on a valid/ready stream
// with a sticky overrun flag.

// One CIC channel: integrators run at the PDM rate, the comb chain and
// output scaling are evaluated once per decimation strobe.
module pdm_cic_chan #(
    parameter int N         = 3,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16,
    parameter int SHR       = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 sample,
    input  logic                 bit_in,
    input  logic                 dec,
    input  logic [2:0]           gain_shift,
    output logic [OUT_WIDTH-1:0] pcm
);
    // Negative SHR means the filter output is narrower than the PCM word.
    localparam int SHR_R = (SHR > 0) ? SHR : 0;
    localparam int SHR_L = (SHR < 0) ? -SHR : 0;
    // Headroom for the 0..7 gain shift plus any left alignment.
    localparam int EW    = ACC_WIDTH + 8 + SHR_L;
    localparam logic signed [EW-1:0] MAXV = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH-1:0] step;
    logic [ACC_WIDTH-1:0] cic_out;
    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] shl;
    logic signed [EW-1:0] scl;
    logic [OUT_WIDTH-1:0] sat;

    // PDM bit maps to +1 / -1.
    assign step = bit_in ? ACC_WIDTH'(1) : {ACC_WIDTH{1'b1}};

    for (genvar k = 0; k < N; k++) begin : g_stage
        logic [ACC_WIDTH-1:0] integ;
        logic [ACC_WIDTH-1:0] dly;
        logic [ACC_WIDTH-1:0] int_in;
        logic [ACC_WIDTH-1:0] c_in;
        logic [ACC_WIDTH-1:0] c_out;

        if (k == 0) begin : g_head
            assign int_in = step;
            assign c_in   = g_stage[N-1].integ;
        end else begin : g_body
            assign int_in = g_stage[k-1].integ;
            assign c_in   = g_stage[k-1].c_out;
        end

        assign c_out = c_in - dly;

        // Integrate on this channel's sample edge; comb delay keeps last decimation's input.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                integ <= '0;
                dly   <= '0;
            end else if (clear) begin
                integ <= '0;
                dly   <= '0;
            end else begin
                if (sample) integ <= integ + int_in;
                if (dec)    dly   <= c_in;
            end
        end
    end

    assign cic_out = g_stage[N-1].c_out;

    // Gain, alignment to OUT_WIDTH and saturation of the signed comb result.
    always_comb begin
        ext = {{(EW-ACC_WIDTH){cic_out[ACC_WIDTH-1]}}, cic_out};
        shl = ext <<< gain_shift;
        scl = (shl >>> SHR_R) <<< SHR_L;
        if (scl > MAXV)      sat = MAXV[OUT_WIDTH-1:0];
        else if (scl < MINV) sat = MINV[OUT_WIDTH-1:0];
        else                 sat = scl[OUT_WIDTH-1:0];
    end

    // Scaled sample is captured on the decimate strobe cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     pcm <= '0;
        else if (clear) pcm <= '0;
        else if (dec)   pcm <= sat;
    end
endmodule

module pdm_stereo_capture #(
    parameter int CLK_DIV    = 16,
    parameter int CIC_STAGES = 3,
    parameter int DECIMATION = 64,
    parameter int OUT_WIDTH  = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [2:0]             gain_shift,
    output logic                   pdm_clk,
    input  logic                   pdm_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*OUT_WIDTH-1:0] out_data,
    output logic                   overrun,
    input  logic                   overrun_clr
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int DEC_W = $clog2(DECIMATION);
    localparam int BITS  = CIC_STAGES * DEC_W + 1;

    logic [DIV_W-1:0]               div_cnt;
    logic [DEC_W-1:0]               dec_cnt;
    logic                           tc;
    logic [1:0]                     smp;
    logic                           dec_hit;
    // [0]: decimate strobe (combs run), [1]: scaled frame ready for output.
    logic [1:0]                     vld_pipe;
    logic [1:0][OUT_WIDTH-1:0]      pcm;
    logic                           load;
    logic                           drop;

    assign tc      = enable && (div_cnt == DIV_W'(CLK_DIV - 1));
    // ch0 is taken as pdm_clk falls, ch1 as it rises.
    assign smp[0]  = tc && pdm_clk;
    assign smp[1]  = tc && !pdm_clk;
    assign dec_hit = smp[1] && (dec_cnt == {DEC_W{1'b1}});

    // Divider: pdm_clk toggles every CLK_DIV enabled cycles, parks low when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pdm_clk <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            pdm_clk <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            pdm_clk <= ~pdm_clk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Decimation counter on ch1 samples and the strobe pipeline behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt  <= '0;
            vld_pipe <= '0;
        end else if (!enable) begin
            dec_cnt  <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], dec_hit};
            if (smp[1]) dec_cnt <= dec_cnt + DEC_W'(1);
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        pdm_cic_chan #(
            .N         (CIC_STAGES),
            .ACC_WIDTH (ACC_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .SHR       (BITS - OUT_WIDTH)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (!enable),
            .sample     (smp[ch]),
            .bit_in     (pdm_data),
            .dec        (vld_pipe[0]),
            .gain_shift (gain_shift),
            .pcm        (pcm[ch])
        );
    end

    assign load = enable && vld_pipe[1] && (!out_valid || out_ready);
    assign drop = enable && vld_pipe[1] && out_valid && !out_ready;

    // Output register: load when the slot is free or draining, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (!enable) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= pcm;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overrun; a drop wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           overrun <= 1'b0;
        else if (drop)        overrun <= 1'b1;
        else if (overrun_clr) overrun <= 1'b0;
    end
endmodule

// File: tb/tb_pdm_stereo_capture.sv
// Bench for pdm_stereo_capture: drives PDM stimulus per half period and
// compares frames against a CIC reference expressed as an FIR of boxcars.
module tb_pdm_stereo_capture;
    localparam int CLK_DIV = 16;
    localparam int N       = 3;
    localparam int R       = 64;
    localparam int OW      = 16;
    localparam int AW      = 32;
    localparam int BITS    = N * $clog2(R) + 1;
    localparam int SHR     = BITS - OW;
    localparam int SHR_R   = (SHR > 0) ? SHR : 0;
    localparam int SHR_L   = (SHR < 0) ? -SHR : 0;
    localparam longint SMAX = (longint'(1) <<< (OW - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (OW - 1));

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [2:0]    gain_shift = 3'd0;
    logic          pdm_clk;
    logic          pdm_data = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [2*OW-1:0] out_data;
    logic          overrun;
    logic          overrun_clr = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    // Reference state: impulse response, per-channel sample history, handshake view.
    int h[$];
    int q0[$];
    int q1[$];
    int hc, n1, due, mode;
    bit m_pclk, m_valid, m_ovr, last_fire;
    logic [2*OW-1:0] m_data, pend, saved_a;

    pdm_stereo_capture #(
        .CLK_DIV(CLK_DIV), .CIC_STAGES(N), .DECIMATION(R), .OUT_WIDTH(OW), .ACC_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .gain_shift(gain_shift),
        .pdm_clk(pdm_clk), .pdm_data(pdm_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // N-fold convolution of a length-R boxcar.
    function automatic void build_h();
        int t[$];
        int s;
        h = {1};
        for (int st = 0; st < N; st++) begin
            t = {};
            for (int j = 0; j < h.size() + R - 1; j++) begin
                s = 0;
                for (int i = 0; i < R; i++)
                    if (j - i >= 0 && j - i < h.size()) s += h[j - i];
                t.push_back(s);
            end
            h = t;
        end
    endfunction

    // Filter output for one channel at the current decimation point, scaled and saturated.
    // The integrator cascade delays the newest sample by N-1 PDM periods.
    function automatic logic [OW-1:0] chan_out(input bit ch);
        longint acc;
        int n, idx;
        acc = 0;
        n = ch ? q1.size() : q0.size();
        for (int j = 0; j < h.size(); j++) begin
            idx = n - N - j;
            if (idx >= 0) acc += longint'(h[j]) * (ch ? q1[idx] : q0[idx]);
        end
        acc = acc <<< gain_shift;
        acc = (acc >>> SHR_R) <<< SHR_L;
        if (acc > SMAX) acc = SMAX;
        if (acc < SMIN) acc = SMIN;
        return acc[OW-1:0];
    endfunction

    function automatic void clear_model();
        q0.delete();
        q1.delete();
        n1 = 0;
        hc = 0;
        due = 0;
        m_pclk = 1'b0;
        last_fire = 1'b0;
    endfunction

    // Next PDM bit; the upcoming half period feeds ch1 when pdm_clk is low.
    function automatic logic gen_bit();
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return m_pclk;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // One clock edge: advance the reference and check around each frame delivery.
    task automatic tick();
        bit rdy, clr, en, rs, d, fire, drop;
        rdy = out_ready; clr = overrun_clr; en = enable; rs = rst_n; d = pdm_data;
        @(posedge clk);
        #1;
        fire = 1'b0;
        if (!rs) begin
            clear_model();
            m_valid = 1'b0; m_data = '0; m_ovr = 1'b0;
        end else if (!en) begin
            clear_model();
            m_valid = 1'b0;
            if (clr) m_ovr = 1'b0;
        end else begin
            if (due > 0) begin due--; fire = (due == 0); end
            drop = fire && m_valid && !rdy;
            if (fire && !drop) begin m_valid = 1'b1; m_data = pend; end
            else if (m_valid && rdy) m_valid = 1'b0;
            if (drop) m_ovr = 1'b1;
            else if (clr) m_ovr = 1'b0;
            hc++;
            if (hc == CLK_DIV) begin
                hc = 0;
                m_pclk = !m_pclk;
                if (m_pclk) begin
                    q1.push_back(d ? 1 : -1);
                    n1++;
                    if (n1 % R == 0) begin
                        pend = {chan_out(1'b1), chan_out(1'b0)};
                        due = 2;
                    end
                end else begin
                    q0.push_back(d ? 1 : -1);
                end
            end
            if (fire || last_fire || due == 1) begin
                chk("valid", out_valid, m_valid);
                chk("pdm_clk", pdm_clk, m_pclk);
            end
            if (fire) begin
                chk("data", out_data, m_data);
                chk("overrun", overrun, m_ovr);
            end
            last_fire = fire;
        end
    endtask

    task automatic run_halves(input int n);
        for (int i = 0; i < n; i++) begin
            pdm_data = gen_bit();
            repeat (CLK_DIV) tick();
        end
    endtask

    initial begin
        build_h();
        clear_model();
        m_valid = 1'b0; m_data = '0; m_ovr = 1'b0; mode = 0;
        repeat (3) tick();
        chk("rst_pclk", pdm_clk, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        enable = 1'b1;

        // Constant and alternating patterns settle to saturated rails.
        mode = 0; run_halves(5 * 128);
        chk("const1", out_data, 32'h7FFF_7FFF);
        mode = 1; run_halves(4 * 128);
        chk("const0", out_data, 32'h8000_8000);
        mode = 2; run_halves(4 * 128);
        chk("toggle", out_data, 32'h8000_7FFF);

        // Random density, unity and 8x gain.
        mode = 3; run_halves(5 * 128);
        gain_shift = 3'd3; run_halves(5 * 128);

        // Backpressure: hold first frame, drop the next two.
        out_ready = 1'b0;
        run_halves(128);
        saved_a = m_data;
        run_halves(128);
        chk("hold1", out_data, saved_a);
        chk("ovr_drop", overrun, 1);
        run_halves(127);
        pdm_data = gen_bit();
        tick();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_set_clr", overrun, 1);
        chk("hold2", out_data, saved_a);
        repeat (CLK_DIV - 2) tick();

        // Disable mid-decimation with pdm_clk high and a frame held.
        run_halves(51);
        repeat (5) tick();
        chk("pclk_mid", pdm_clk, 1);
        enable = 1'b0;
        tick();
        chk("dis_pclk", pdm_clk, 0);
        chk("dis_valid", out_valid, 0);
        chk("dis_ovr", overrun, 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("clr_alone", overrun, 0);
        enable = 1'b1;
        out_ready = 1'b1;
        run_halves(256);

        // Asynchronous reset between edges with valid, overrun and pdm_clk all high.
        out_ready = 1'b0;
        run_halves(256);
        run_halves(51);
        repeat (3) tick();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_pclk", pdm_clk, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_ovr", overrun, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        run_halves(256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
